// File: rtl/id_stage_sb.sv
// MIPS decode stage: registered ID->EXE slot with valid/ready, per-register
// scoreboard of in-flight writes, optional EXE/MEM forwarding and registered redirect.
module id_stage_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned CNTW   = 2,
    parameter int unsigned FWD_EN = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_pc,
    input  logic [31:0]     in_inst,
    output logic [AW-1:0]   rs_addr,
    output logic [AW-1:0]   rt_addr,
    input  logic [XLEN-1:0] rs_value,
    input  logic [XLEN-1:0] rt_value,
    input  logic            exe_fwd_en,
    input  logic            mem_fwd_en,
    input  logic [AW-1:0]   exe_fwd_dest,
    input  logic [AW-1:0]   mem_fwd_dest,
    input  logic [XLEN-1:0] exe_fwd_data,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            exe_is_load,
    input  logic            wb_commit,
    input  logic [AW-1:0]   wb_dest,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic            out_wen,
    output logic [AW-1:0]   out_wdest,
    output logic [31:0]     out_inst,
    output logic            jbr_taken,
    output logic [31:0]     jbr_target
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [15:0] imm;
    logic [31:0] pc4;

    logic          uses_rs, uses_rt, wen_d, wen;
    logic          is_br, is_j, is_jr;
    logic [AW-1:0] wdest_d, wdest;

    logic [1:0][AW-1:0]   src_addr;
    logic [1:0]           src_used;
    logic [1:0][XLEN-1:0] src_rf;
    logic [1:0][CNTW-1:0] src_cnt;
    logic [1:0][XLEN-1:0] src_val;
    logic [1:0]           src_stall;
    logic [1:0]           exe_hit, mem_hit;

    logic [CNTW-1:0] cnt [NREG];
    logic [NREG-1:0] sb_inc, sb_dec;

    logic        stall, fire_in;
    logic        taken;
    logic [31:0] target;

    assign op      = in_inst[31:26];
    assign funct   = in_inst[5:0];
    assign rt_f    = in_inst[20:16];
    assign rd_f    = in_inst[15:11];
    assign imm     = in_inst[15:0];
    assign pc4     = in_pc + 32'd4;
    assign rs_addr = AW'(in_inst[25:21]);
    assign rt_addr = AW'(rt_f);

    // MIPS-I subset decode: source usage, destination select, control-flow class
    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        wen_d   = 1'b0;
        wdest_d = AW'(rt_f);
        is_br   = 1'b0;
        is_j    = 1'b0;
        is_jr   = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03: begin
                        uses_rt = 1'b1; wen_d = 1'b1; wdest_d = AW'(rd_f);
                    end
                    6'h04, 6'h06, 6'h07, 6'h21, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        uses_rs = 1'b1; uses_rt = 1'b1; wen_d = 1'b1; wdest_d = AW'(rd_f);
                    end
                    6'h08: begin
                        uses_rs = 1'b1; is_jr = 1'b1;
                    end
                    6'h09: begin
                        uses_rs = 1'b1; is_jr = 1'b1; wen_d = 1'b1; wdest_d = AW'(rd_f);
                    end
                    default: ;
                endcase
            end
            6'h01: begin
                uses_rs = 1'b1; is_br = (rt_f[4:1] == 4'd0);
            end
            6'h02: is_j = 1'b1;
            6'h03: begin
                is_j = 1'b1; wen_d = 1'b1; wdest_d = AW'(5'd31);
            end
            6'h04, 6'h05: begin
                uses_rs = 1'b1; uses_rt = 1'b1; is_br = 1'b1;
            end
            6'h06, 6'h07: begin
                uses_rs = 1'b1; is_br = 1'b1;
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                uses_rs = 1'b1; wen_d = 1'b1;
            end
            6'h0F: wen_d = 1'b1;
            6'h28, 6'h29, 6'h2B: begin
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // Writes to $0 are architecturally dropped, so they are never tracked
    assign wen   = wen_d & (wdest_d != '0);
    assign wdest = wen ? wdest_d : '0;

    assign src_addr = {rt_addr, rs_addr};
    assign src_used = {uses_rt, uses_rs};
    assign src_rf   = {rt_value, rs_value};
    assign src_cnt  = {cnt[rt_addr], cnt[rs_addr]};

    // Operand resolution: EXE beats MEM beats regfile; pending writers with no visible result stall
    always_comb begin
        src_val   = src_rf;
        src_stall = '0;
        exe_hit   = '0;
        mem_hit   = '0;
        for (int i = 0; i < 2; i++) begin
            exe_hit[i] = exe_fwd_en && (exe_fwd_dest == src_addr[i]);
            mem_hit[i] = mem_fwd_en && (mem_fwd_dest == src_addr[i]);
            if (src_used[i] && (src_addr[i] != '0)) begin
                if (FWD_EN != 0) begin
                    if (exe_hit[i]) begin
                        src_val[i]   = exe_fwd_data;
                        src_stall[i] = exe_is_load;
                    end else if (mem_hit[i]) begin
                        src_val[i] = mem_fwd_data;
                    end else if (src_cnt[i] != '0) begin
                        src_stall[i] = 1'b1;
                    end
                end else if (src_cnt[i] != '0) begin
                    src_stall[i] = 1'b1;
                end
            end
        end
    end

    // Redirect decision uses the resolved operands
    always_comb begin
        taken  = 1'b0;
        target = pc4 + {{14{imm[15]}}, imm, 2'b00};
        if (is_j) begin
            taken  = 1'b1;
            target = {pc4[31:28], in_inst[25:0], 2'b00};
        end else if (is_jr) begin
            taken  = 1'b1;
            target = 32'(src_val[0]);
        end else if (is_br) begin
            case (op)
                6'h04:   taken = (src_val[0] == src_val[1]);
                6'h05:   taken = (src_val[0] != src_val[1]);
                6'h06:   taken = src_val[0][XLEN-1] | (src_val[0] == '0);
                6'h07:   taken = ~src_val[0][XLEN-1] & (src_val[0] != '0);
                default: taken = rt_f[0] ? ~src_val[0][XLEN-1] : src_val[0][XLEN-1];
            endcase
        end
    end

    assign stall    = (|src_stall) | (wen && (cnt[wdest] == CNT_MAX));
    assign in_ready = ~stall & (~out_valid | out_ready) & ~flush;
    assign fire_in  = in_valid & in_ready;

    // ID->EXE register and one-cycle redirect pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_op1    <= '0;
            out_op2    <= '0;
            out_wen    <= 1'b0;
            out_wdest  <= '0;
            out_inst   <= '0;
            jbr_taken  <= 1'b0;
            jbr_target <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            jbr_taken <= 1'b0;
        end else begin
            jbr_taken <= fire_in & taken;
            if (fire_in) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_op1   <= src_val[0];
                out_op2   <= src_val[1];
                out_wen   <= wen;
                out_wdest <= wdest;
                out_inst  <= in_inst;
                if (taken) jbr_target <= target;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        if (fire_in && wen) sb_inc[wdest] = 1'b1;
        if (wb_commit && (wb_dest != '0)) sb_dec[wb_dest] = 1'b1;
    end

    // Scoreboard: simultaneous issue and retire on one register cancel; retire at zero is held
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (sb_inc[i] && !sb_dec[i]) begin
                    cnt[i] <= cnt[i] + CNTW'(1);
                end else if (!sb_inc[i] && sb_dec[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNTW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_id_stage_sb.sv
// Directed bench for id_stage_sb: forwarding instance (f_*) and no-forwarding instance (n_*).
module tb_id_stage_sb;

    logic        clk;
    logic        resetn;
    logic        f_in_valid, n_in_valid;
    logic [31:0] in_pc, in_inst;
    logic        exe_fwd_en, mem_fwd_en, exe_is_load;
    logic [4:0]  exe_fwd_dest, mem_fwd_dest;
    logic [31:0] exe_fwd_data, mem_fwd_data;
    logic        wb_commit;
    logic [4:0]  wb_dest;
    logic        flush, out_ready;

    logic        f_in_ready, f_out_valid, f_out_wen, f_jbr_taken;
    logic [4:0]  f_rs_addr, f_rt_addr, f_out_wdest;
    logic [31:0] f_rs_value, f_rt_value, f_out_pc, f_out_op1, f_out_op2, f_out_inst, f_jbr_target;
    logic        n_in_ready, n_out_valid, n_out_wen, n_jbr_taken;
    logic [4:0]  n_rs_addr, n_rt_addr, n_out_wdest;
    logic [31:0] n_rs_value, n_rt_value, n_out_pc, n_out_op1, n_out_op2, n_out_inst, n_jbr_target;

    logic [31:0] rf [32];
    int          n_checks;
    int          n_fail;

    assign f_rs_value = rf[f_rs_addr];
    assign f_rt_value = rf[f_rt_addr];
    assign n_rs_value = rf[n_rs_addr];
    assign n_rt_value = rf[n_rt_addr];

    id_stage_sb #(.XLEN(32), .NREG(32), .CNTW(2), .FWD_EN(1)) u_fwd (
        .clk(clk), .resetn(resetn),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .rs_addr(f_rs_addr), .rt_addr(f_rt_addr), .rs_value(f_rs_value), .rt_value(f_rt_value),
        .exe_fwd_en(exe_fwd_en), .mem_fwd_en(mem_fwd_en),
        .exe_fwd_dest(exe_fwd_dest), .mem_fwd_dest(mem_fwd_dest),
        .exe_fwd_data(exe_fwd_data), .mem_fwd_data(mem_fwd_data),
        .exe_is_load(exe_is_load), .wb_commit(wb_commit), .wb_dest(wb_dest), .flush(flush),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_pc(f_out_pc),
        .out_op1(f_out_op1), .out_op2(f_out_op2), .out_wen(f_out_wen), .out_wdest(f_out_wdest),
        .out_inst(f_out_inst), .jbr_taken(f_jbr_taken), .jbr_target(f_jbr_target)
    );

    id_stage_sb #(.XLEN(32), .NREG(32), .CNTW(2), .FWD_EN(0)) u_nofwd (
        .clk(clk), .resetn(resetn),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .rs_addr(n_rs_addr), .rt_addr(n_rt_addr), .rs_value(n_rs_value), .rt_value(n_rt_value),
        .exe_fwd_en(exe_fwd_en), .mem_fwd_en(mem_fwd_en),
        .exe_fwd_dest(exe_fwd_dest), .mem_fwd_dest(mem_fwd_dest),
        .exe_fwd_data(exe_fwd_data), .mem_fwd_data(mem_fwd_data),
        .exe_is_load(exe_is_load), .wb_commit(wb_commit), .wb_dest(wb_dest), .flush(flush),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
        .out_op1(n_out_op1), .out_op2(n_out_op2), .out_wen(n_out_wen), .out_wdest(n_out_wdest),
        .out_inst(n_out_inst), .jbr_taken(n_jbr_taken), .jbr_target(n_jbr_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {opc, rs, rt, im};
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
        in_pc   = pc;
        in_inst = inst;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) << 4;
        rf[2] = 32'h10;
        resetn = 1'b0; f_in_valid = 1'b0; n_in_valid = 1'b0;
        in_pc = '0; in_inst = '0; out_ready = 1'b1; flush = 1'b0;
        exe_fwd_en = 1'b0; mem_fwd_en = 1'b0; exe_is_load = 1'b0;
        exe_fwd_dest = '0; mem_fwd_dest = '0; exe_fwd_data = '0; mem_fwd_data = '0;
        wb_commit = 1'b0; wb_dest = '0;

        tick(); tick();
        chk("rst_out_valid", 32'(f_out_valid), 32'd0);
        chk("rst_jbr_taken", 32'(f_jbr_taken), 32'd0);
        chk("rst_out_pc", f_out_pc, 32'd0);
        chk("rst_jbr_target", f_jbr_target, 32'd0);
        resetn = 1'b1;

        // back-to-back dependent ADDU with EXE forwarding
        f_in_valid = 1'b1;
        drive(32'h10, enc_r(5'd1, 5'd2, 5'd3, 6'h21));
        chk("addu3_ready", 32'(f_in_ready), 32'd1);
        tick();
        chk("addu3_valid", 32'(f_out_valid), 32'd1);
        chk("addu3_op1", f_out_op1, 32'h10);
        chk("addu3_wdest", 32'(f_out_wdest), 32'd3);
        exe_fwd_en = 1'b1; exe_fwd_dest = 5'd3; exe_fwd_data = 32'h5;
        drive(32'h14, enc_r(5'd3, 5'd3, 5'd4, 6'h21));
        chk("addu4_ready", 32'(f_in_ready), 32'd1);
        tick();
        chk("addu4_op1", f_out_op1, 32'h5);
        chk("addu4_op2", f_out_op2, 32'h5);
        chk("addu4_wdest", 32'(f_out_wdest), 32'd4);
        chk("addu4_pc", f_out_pc, 32'h14);

        // load-use stall, then MEM forwarding
        exe_fwd_en = 1'b0;
        drive(32'h18, enc_i(6'h23, 5'd1, 5'd5, 16'd0));
        chk("lw_ready", 32'(f_in_ready), 32'd1);
        tick();
        chk("lw_wdest", 32'(f_out_wdest), 32'd5);
        exe_fwd_en = 1'b1; exe_fwd_dest = 5'd5; exe_is_load = 1'b1;
        drive(32'h1c, enc_r(5'd5, 5'd0, 5'd6, 6'h21));
        chk("loaduse_stall", 32'(f_in_ready), 32'd0);
        tick();
        chk("loaduse_bubble", 32'(f_out_valid), 32'd0);
        exe_fwd_en = 1'b0; exe_is_load = 1'b0;
        mem_fwd_en = 1'b1; mem_fwd_dest = 5'd5; mem_fwd_data = 32'hDEAD;
        #1;
        chk("memfwd_ready", 32'(f_in_ready), 32'd1);
        tick();
        chk("memfwd_op1", f_out_op1, 32'hDEAD);
        chk("memfwd_op2", f_out_op2, 32'd0);
        chk("memfwd_wdest", 32'(f_out_wdest), 32'd6);
        mem_fwd_en = 1'b0;

        // scoreboard saturation on $8
        for (int k = 0; k < 3; k++) begin
            drive(32'h20 + 32'(k) * 4, enc_i(6'h09, 5'd0, 5'd8, 16'd1));
            chk("addiu8_ready", 32'(f_in_ready), 32'd1);
            tick();
        end
        drive(32'h2c, enc_i(6'h09, 5'd0, 5'd8, 16'd1));
        chk("sat_stall", 32'(f_in_ready), 32'd0);
        wb_commit = 1'b1; wb_dest = 5'd8;
        #1;
        chk("sat_commit_cycle", 32'(f_in_ready), 32'd0);
        tick();
        wb_commit = 1'b0;
        #1;
        chk("sat_release", 32'(f_in_ready), 32'd1);
        tick();
        chk("sat_issue_valid", 32'(f_out_valid), 32'd1);
        chk("sat_issue_pc", f_out_pc, 32'h2c);
        #1;
        chk("sat_again", 32'(f_in_ready), 32'd0);

        // taken BEQ with backpressure on the delay slot
        drive(32'h100, enc_i(6'h04, 5'd1, 5'd2, 16'd4));
        chk("beq_ready", 32'(f_in_ready), 32'd1);
        tick();
        chk("beq_taken", 32'(f_jbr_taken), 32'd1);
        chk("beq_target", f_jbr_target, 32'h114);
        chk("beq_pc", f_out_pc, 32'h100);
        chk("beq_wen", 32'(f_out_wen), 32'd0);
        out_ready = 1'b0;
        drive(32'h104, enc_r(5'd1, 5'd2, 5'd9, 6'h21));
        chk("bp_ready", 32'(f_in_ready), 32'd0);
        tick();
        chk("beq_pulse_end", 32'(f_jbr_taken), 32'd0);
        chk("bp_pc", f_out_pc, 32'h100);
        tick();
        chk("bp_valid", 32'(f_out_valid), 32'd1);
        chk("bp_inst", f_out_inst, enc_i(6'h04, 5'd1, 5'd2, 16'd4));
        out_ready = 1'b1;
        #1;
        chk("slot_ready", 32'(f_in_ready), 32'd1);
        tick();
        chk("slot_pc", f_out_pc, 32'h104);
        chk("slot_taken", 32'(f_jbr_taken), 32'd0);

        // second $3 writer, then flush clears the scoreboard
        drive(32'h108, enc_r(5'd1, 5'd2, 5'd3, 6'h21));
        tick();
        chk("pre_flush_valid", 32'(f_out_valid), 32'd1);
        drive(32'h10c, enc_r(5'd3, 5'd0, 5'd10, 6'h21));
        chk("dep3_stall", 32'(f_in_ready), 32'd0);
        flush = 1'b1; wb_commit = 1'b1; wb_dest = 5'd3;
        #1;
        chk("flush_ready", 32'(f_in_ready), 32'd0);
        tick();
        chk("flush_valid", 32'(f_out_valid), 32'd0);
        flush = 1'b0; wb_commit = 1'b0;
        #1;
        chk("post_flush_ready", 32'(f_in_ready), 32'd1);
        tick();
        chk("post_flush_op1", f_out_op1, 32'h30);
        chk("post_flush_valid", 32'(f_out_valid), 32'd1);
        f_in_valid = 1'b0;

        // asynchronous reset mid-stream
        #3;
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(f_out_valid), 32'd0);
        chk("async_rst_pc", f_out_pc, 32'd0);
        chk("async_rst_op1", f_out_op1, 32'd0);
        chk("async_rst_inst", f_out_inst, 32'd0);
        chk("async_rst_target", f_jbr_target, 32'd0);
        tick();
        resetn = 1'b1;

        // no-forwarding instance waits for retirement
        n_in_valid = 1'b1;
        drive(32'h200, enc_i(6'h09, 5'd0, 5'd7, 16'd5));
        chk("nf_addiu_ready", 32'(n_in_ready), 32'd1);
        tick();
        chk("nf_addiu_wdest", 32'(n_out_wdest), 32'd7);
        exe_fwd_en = 1'b1; exe_fwd_dest = 5'd7; exe_fwd_data = 32'h77;
        drive(32'h204, enc_r(5'd7, 5'd0, 5'd11, 6'h21));
        chk("nf_dep_stall", 32'(n_in_ready), 32'd0);
        tick();
        chk("nf_dep_stall2", 32'(n_in_ready), 32'd0);
        wb_commit = 1'b1; wb_dest = 5'd7;
        #1;
        chk("nf_commit_cycle", 32'(n_in_ready), 32'd0);
        tick();
        wb_commit = 1'b0;
        #1;
        chk("nf_release", 32'(n_in_ready), 32'd1);
        tick();
        chk("nf_op1", n_out_op1, 32'h70);
        chk("nf_wdest", 32'(n_out_wdest), 32'd11);
        n_in_valid = 1'b0; exe_fwd_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
